// File: rtl/lock_ctrl_multi.sv
// lock_ctrl_multi: keypad door-lock controller with N user PINs, a master PIN,
// escalating lockout after failed attempts, door-open alarm and a setup handshake.
//
// Handshake semantics: key_valid and setup_end are single-cycle strobes with no
// ready back-pressure. A strobe is consumed on the clock edge where it is high
// if the controller is in a state that accepts it (keys in ENTRY, setup_end in
// SETUP). Otherwise it is dropped.
//
// All outputs are registered. Each output value is computed from the next state,
// so it changes on the same edge that enters the state.
module lock_ctrl_multi #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int PIN_DIGITS = 4,
  parameter int N_USERS    = 4,
  localparam int PIN_W     = PIN_DIGITS * 4,
  localparam int UID_W     = (N_USERS > 1) ? $clog2(N_USERS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       door_closed,
  input  logic                       inner_btn,
  input  logic                       key_valid,
  input  logic [3:0]                 key_code,
  input  logic [N_USERS*PIN_W-1:0]   user_pins,
  input  logic [N_USERS-1:0]         user_en,
  input  logic [PIN_W-1:0]           master_pin,
  input  logic                       bip_en,
  input  logic [6:0]                 bip_time,
  input  logic [6:0]                 lock_time,
  input  logic                       setup_end,
  output logic                       lock,
  output logic                       bip,
  output logic                       setup_on,
  output logic [PIN_W-1:0]           bcd_out,
  output logic                       bcd_en,
  output logic [UID_W-1:0]           user_id,
  output logic [3:0]                 fail_count,
  output logic [2:0]                 state_dbg
);

  localparam int PRESC_W = $clog2(CLK_FREQ);
  localparam int CNT_W   = $clog2(PIN_DIGITS + 1);

  typedef enum logic [2:0] {
    S_RESET    = 3'd0,
    S_ENTRY    = 3'd1,
    S_CHECK    = 3'd2,
    S_LOCKOUT  = 3'd3,
    S_SETUP    = 3'd4,
    S_UNLOCKED = 3'd5,
    S_OPEN     = 3'd6,
    S_RELOCK   = 3'd7
  } state_t;

  state_t               state_q, state_d;
  logic [PIN_W-1:0]     entry_q, entry_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [7:0]           sec_q, sec_d;
  logic                 lock_q, lock_d;
  logic                 bip_q, bip_d;
  logic                 setup_on_q, setup_on_d;
  logic [PIN_W-1:0]     bcd_out_q, bcd_out_d;
  logic                 bcd_en_q, bcd_en_d;
  logic [UID_W-1:0]     user_id_q, user_id_d;
  logic [3:0]           fail_count_q, fail_count_d;

  logic                 key_digit, key_star, key_hash;
  logic                 entry_full;
  logic                 master_hit;
  logic                 user_hit;
  logic [UID_W-1:0]     user_idx;
  logic [7:0]           lockout_secs;

  assign key_digit  = key_valid && (key_code <= 4'd9);
  assign key_star   = key_valid && (key_code == 4'hA);
  assign key_hash   = key_valid && (key_code == 4'hB);
  assign entry_full = (count_q == CNT_W'(PIN_DIGITS));
  assign master_hit = (entry_q == master_pin);

  // Lowest enabled slot whose stored PIN equals the entry register
  always_comb begin
    user_hit = 1'b0;
    user_idx = '0;
    for (int k = N_USERS - 1; k >= 0; k--) begin
      if (user_en[k] && (entry_q == user_pins[k*PIN_W +: PIN_W])) begin
        user_hit = 1'b1;
        user_idx = UID_W'(k);
      end
    end
  end

  // Lockout length in seconds, escalating with the consecutive failure count
  always_comb begin
    if (fail_count_q <= 4'd2)      lockout_secs = 8'd1;
    else if (fail_count_q == 4'd3) lockout_secs = 8'd10;
    else if (fail_count_q == 4'd4) lockout_secs = 8'd20;
    else                           lockout_secs = 8'd30;
  end

  // Next-state, entry register, match bookkeeping
  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    count_d      = count_q;
    user_id_d    = user_id_q;
    fail_count_d = fail_count_q;

    case (state_q)
      S_RESET: begin
        if (door_closed) state_d = S_ENTRY;
      end
      S_ENTRY: begin
        if (key_star) begin
          state_d = S_CHECK;
        end else if (inner_btn) begin
          state_d = S_UNLOCKED;
        end else if (key_hash) begin
          entry_d = '0;
          count_d = '0;
        end else if (key_digit) begin
          entry_d = {entry_q[PIN_W-5:0], key_code};
          if (!entry_full) count_d = count_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (entry_full && master_hit) begin
          state_d      = S_SETUP;
          fail_count_d = 4'd0;
        end else if (entry_full && user_hit) begin
          state_d      = S_UNLOCKED;
          user_id_d    = user_idx;
          fail_count_d = 4'd0;
        end else begin
          state_d      = S_LOCKOUT;
          fail_count_d = (fail_count_q == 4'hF) ? 4'hF : fail_count_q + 4'd1;
        end
      end
      S_LOCKOUT: begin
        if (sec_q >= lockout_secs) state_d = S_ENTRY;
      end
      S_SETUP: begin
        if (setup_end) state_d = S_ENTRY;
      end
      S_UNLOCKED: begin
        if (!door_closed) state_d = S_OPEN;
        else if ((sec_q >= {1'b0, lock_time}) || inner_btn) state_d = S_RELOCK;
      end
      S_OPEN: begin
        if (door_closed) state_d = S_UNLOCKED;
      end
      S_RELOCK: begin
        state_d = S_ENTRY;
      end
      default: begin
        state_d = S_RESET;
      end
    endcase

    // The entry register only carries meaning while a PIN is being typed or checked
    if ((state_d != S_ENTRY) && (state_d != S_CHECK)) begin
      entry_d = '0;
      count_d = '0;
    end
  end

  // Prescaler and seconds counter, restarted on every state change
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    if (state_d != state_q) begin
      presc_d = '0;
      sec_d   = 8'd0;
    end else if (presc_q == PRESC_W'(CLK_FREQ - 1)) begin
      presc_d = '0;
      sec_d   = (sec_q == 8'hFF) ? 8'hFF : sec_q + 8'd1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Output values for the state being entered
  always_comb begin
    lock_d     = !((state_d == S_RESET) || (state_d == S_UNLOCKED) || (state_d == S_OPEN));
    setup_on_d = (state_d == S_SETUP);
    // Alarm latches once the open-door time expires and drops when OPEN is left
    bip_d      = (state_q == S_OPEN) && (state_d == S_OPEN) &&
                 (bip_q || (bip_en && (sec_q >= {1'b0, bip_time})));
    bcd_en_d   = 1'b0;
    bcd_out_d  = {PIN_DIGITS{4'hF}};
    case (state_d)
      S_ENTRY: begin
        bcd_en_d = 1'b1;
        for (int j = 0; j < PIN_DIGITS; j++) begin
          bcd_out_d[j*4 +: 4] = (j < int'(count_d)) ? entry_d[j*4 +: 4] : 4'hF;
        end
      end
      S_LOCKOUT: begin
        bcd_en_d  = 1'b1;
        bcd_out_d = {PIN_DIGITS{4'hE}};
      end
      default: begin
        bcd_en_d  = 1'b0;
        bcd_out_d = {PIN_DIGITS{4'hF}};
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RESET;
      entry_q      <= '0;
      count_q      <= '0;
      presc_q      <= '0;
      sec_q        <= 8'd0;
      lock_q       <= 1'b0;
      bip_q        <= 1'b0;
      setup_on_q   <= 1'b0;
      bcd_out_q    <= {PIN_DIGITS{4'hF}};
      bcd_en_q     <= 1'b0;
      user_id_q    <= '0;
      fail_count_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      count_q      <= count_d;
      presc_q      <= presc_d;
      sec_q        <= sec_d;
      lock_q       <= lock_d;
      bip_q        <= bip_d;
      setup_on_q   <= setup_on_d;
      bcd_out_q    <= bcd_out_d;
      bcd_en_q     <= bcd_en_d;
      user_id_q    <= user_id_d;
      fail_count_q <= fail_count_d;
    end
  end

  assign lock       = lock_q;
  assign bip        = bip_q;
  assign setup_on   = setup_on_q;
  assign bcd_out    = bcd_out_q;
  assign bcd_en     = bcd_en_q;
  assign user_id    = user_id_q;
  assign fail_count = fail_count_q;
  assign state_dbg  = state_q;

endmodule
